// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch (IF) and load/store (LS), one transaction in flight, with WAIT timeout.
// Define ARB_RR_EN for round-robin arbitration; default is fixed LS-over-IF priority.
module mem_port_arbiter #(
  parameter  int MEM_DEPTH      = 8,
  parameter  int DATA_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  system_stall,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_resp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req_valid,
  input  logic                  ls_req_we,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_resp_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  mem_req_valid,
  input  logic                  mem_data_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b11,
    S_DONE  = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner_ls;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [7:0]            r_count;
  logic                  r_err;

  logic                  w_grant;
  logic                  w_sel_ls;
  logic [7:0]            w_count_inc;
  logic                  w_expire;
  logic                  w_drive;

  assign w_grant     = (r_state == S_IDLE) && !system_stall && (if_req_valid || ls_req_valid);
  assign w_count_inc = r_count + 8'd1;
  // Expiry is judged on the incremented count so the abort lands exactly TIMEOUT_CYCLES after ISSUE.
  assign w_expire    = (w_count_inc == 8'(TIMEOUT_CYCLES - 1));

`ifdef ARB_RR_EN
  logic r_rr_ptr;  // 0: IF wins a tie, 1: LS wins a tie

  assign w_sel_ls = ls_req_valid && (!if_req_valid || r_rr_ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_rr_ptr <= 1'b0;
    else if (w_grant) r_rr_ptr <= !w_sel_ls;
  end
`else
  assign w_sel_ls = ls_req_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_data_valid || w_expire) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_ls <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner_ls <= w_sel_ls;
            r_we       <= w_sel_ls && ls_req_we;
            r_addr     <= w_sel_ls ? ls_req_addr : if_req_addr;
            r_wdata    <= w_sel_ls ? ls_wdata : '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
          end
        end
        S_ISSUE: r_count <= '0;
        S_WAIT: begin
          if (mem_data_valid) begin
            if (!r_we) r_rdata <= mem_data;
          end else begin
            r_count <= w_count_inc;
            if (w_expire) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    w_drive       = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    bus_err       = 1'b0;
    if_rdata      = '0;
    ls_rdata      = '0;
    case (r_state)
      S_ISSUE, S_WAIT: begin
        mem_req_valid = 1'b1;
        mem_we        = r_we;
        w_drive       = r_we;
      end
      S_DONE: begin
        bus_err = r_err;
        if (r_owner_ls) begin
          ls_resp_valid = 1'b1;
          ls_rdata      = r_err ? '0 : r_rdata;
        end else begin
          if_resp_valid = 1'b1;
          if_rdata      = r_err ? '0 : r_rdata;
        end
      end
      default: ;
    endcase
  end

  assign mem_addr = r_addr;
  assign mem_data = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, reads, store/fetch tie, timeout, stall, reset mid-WAIT.
module tb_mem_port_arbiter;
  localparam int T = 16;

  logic        clk;
  logic        reset;
  logic        system_stall;
  logic        if_req_valid;
  logic [2:0]  if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_rdata;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [2:0]  ls_req_addr;
  logic [31:0] ls_wdata;
  logic        ls_resp_valid;
  logic [31:0] ls_rdata;
  logic        bus_err;
  logic [2:0]  mem_addr;
  wire  [31:0] mem_data;
  logic        mem_we;
  logic        mem_req_valid;
  logic        mem_data_valid;

  logic        tb_drv;
  logic [31:0] tb_drv_data;
  assign mem_data = tb_drv ? tb_drv_data : 32'bz;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.MEM_DEPTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .system_stall  (system_stall),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_we     (ls_req_we),
    .ls_req_addr   (ls_req_addr),
    .ls_wdata      (ls_wdata),
    .ls_resp_valid (ls_resp_valid),
    .ls_rdata      (ls_rdata),
    .bus_err       (bus_err),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_we        (mem_we),
    .mem_req_valid (mem_req_valid),
    .mem_data_valid(mem_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in the ISSUE cycle; memory completes in WAIT cycle k; returns in IDLE.
  task automatic do_txn(input string tag, input logic is_ls, input logic is_we,
                        input logic [2:0] addr, input logic [31:0] data, input int k);
    chk({tag, "_issue_req"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_issue_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, "_issue_we"}, 32'(mem_we), 32'(is_we));
    if (is_we) chk({tag, "_wdata"}, mem_data, data);
    tick();
    repeat (k - 1) tick();
    mem_data_valid = 1'b1;
    if (!is_we) begin
      tb_drv      = 1'b1;
      tb_drv_data = data;
    end
    tick();
    mem_data_valid = 1'b0;
    tb_drv         = 1'b0;
    chk({tag, "_own_resp"}, 32'(is_ls ? ls_resp_valid : if_resp_valid), 32'd1);
    chk({tag, "_other_resp"}, 32'(is_ls ? if_resp_valid : ls_resp_valid), 32'd0);
    chk({tag, "_rdata"}, is_ls ? ls_rdata : if_rdata, is_we ? 32'd0 : data);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_done_req"}, 32'(mem_req_valid), 32'd0);
    if (is_ls) ls_req_valid = 1'b0;
    else       if_req_valid = 1'b0;
    tick();
    chk({tag, "_pulse_len"}, 32'(is_ls ? ls_resp_valid : if_resp_valid), 32'd0);
  endtask

  initial begin
    logic early;
    reset          = 1'b1;
    system_stall   = 1'b0;
    if_req_valid   = 1'b0;
    if_req_addr    = 3'd0;
    ls_req_valid   = 1'b0;
    ls_req_we      = 1'b0;
    ls_req_addr    = 3'd0;
    ls_wdata       = 32'd0;
    mem_data_valid = 1'b0;
    tb_drv         = 1'b0;
    tb_drv_data    = 32'd0;

    repeat (3) tick();
    chk("rst_hold_req", 32'(mem_req_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_if_resp", 32'(if_resp_valid), 32'd0);
    chk("rst_ls_resp", 32'(ls_resp_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);

    if_req_valid = 1'b1;
    if_req_addr  = 3'd3;
    tick();
    do_txn("if_rd", 1'b0, 1'b0, 3'd3, 32'hDEADBEEF, 2);

    if_req_valid = 1'b1;
    if_req_addr  = 3'd1;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = 3'd5;
    ls_wdata     = 32'h0000_1234;
    tick();
`ifdef ARB_RR_EN
    do_txn("tie1_if", 1'b0, 1'b0, 3'd1, 32'hCAFE0001, 1);
    if_req_valid = 1'b1;
    tick();
    do_txn("tie2_ls", 1'b1, 1'b1, 3'd5, 32'h0000_1234, 1);
    tick();
    do_txn("tie2_if", 1'b0, 1'b0, 3'd1, 32'hCAFE0002, 1);
`else
    do_txn("tie_ls", 1'b1, 1'b1, 3'd5, 32'h0000_1234, 1);
    tick();
    do_txn("tie_if", 1'b0, 1'b0, 3'd1, 32'hCAFE0001, 1);
`endif

    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    ls_req_addr  = 3'd2;
    tick();
    chk("to_issue_req", 32'(mem_req_valid), 32'd1);
    early = 1'b0;
    repeat (T - 1) begin
      tick();
      if (ls_resp_valid || bus_err) early = 1'b1;
    end
    chk("to_no_early_resp", 32'(early), 32'd0);
    chk("to_last_wait_req", 32'(mem_req_valid), 32'd1);
    tick();
    chk("to_ls_resp", 32'(ls_resp_valid), 32'd1);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_ls_rdata", ls_rdata, 32'd0);
    chk("to_if_resp", 32'(if_resp_valid), 32'd0);
    ls_req_valid = 1'b0;
    tick();
    chk("to_pulse_len", 32'(bus_err), 32'd0);

    ls_req_valid = 1'b1;
    ls_req_addr  = 3'd7;
    tick();
    do_txn("expiry_tie", 1'b1, 1'b0, 3'd7, 32'h0BADF00D, T - 1);

    system_stall = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 3'd6;
    early        = 1'b0;
    repeat (3) begin
      tick();
      if (mem_req_valid) early = 1'b1;
    end
    chk("stall_no_grant", 32'(early), 32'd0);
    system_stall = 1'b0;
    tick();
    chk("stall_issue_req", 32'(mem_req_valid), 32'd1);
    chk("stall_issue_addr", 32'(mem_addr), 32'd6);
    tick();
    system_stall = 1'b1;
    tick();
    mem_data_valid = 1'b1;
    tb_drv         = 1'b1;
    tb_drv_data    = 32'h5555AAAA;
    tick();
    mem_data_valid = 1'b0;
    tb_drv         = 1'b0;
    chk("stall_wait_resp", 32'(if_resp_valid), 32'd1);
    chk("stall_wait_rdata", if_rdata, 32'h5555AAAA);
    if_req_valid = 1'b0;
    tick();
    system_stall = 1'b0;

    if_req_valid = 1'b1;
    if_req_addr  = 3'd4;
    tick();
    tick();
    chk("rstw_in_wait", 32'(mem_req_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_req_drop", 32'(mem_req_valid), 32'd0);
    chk("rstw_no_resp", 32'(if_resp_valid), 32'd0);
    tick();
    chk("rstw_still_no_resp", 32'(if_resp_valid), 32'd0);
    reset = 1'b0;
    tick();
    do_txn("rstw_retry", 1'b0, 1'b0, 3'd4, 32'h600DCAFE, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
